// File: rtl/timer_pkg.sv
// Shared types and constants for the countdown timer bank.
package timer_pkg;

  typedef enum logic [2:0] {
    IDLE, SET_SEC, SET_MIN, SET_HOUR, RUN, PAUSE, EXPIRED
  } ch_state_t;

  localparam logic [7:0] SEC_MAX  = 8'd59;
  localparam logic [7:0] MIN_MAX  = 8'd59;
  localparam int         SEC_LSB  = 0;
  localparam int         MIN_LSB  = 8;
  localparam int         HOUR_LSB = 16;

  function automatic logic [1:0] field_code(input ch_state_t s);
    case (s)
      SET_SEC:  return 2'd1;
      SET_MIN:  return 2'd2;
      SET_HOUR: return 2'd3;
      default:  return 2'd0;
    endcase
  endfunction

  // Out-of-range values also wrap to 0 so a field can never get stuck above its max.
  function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] max);
    return (v >= max) ? 8'd0 : v + 8'd1;
  endfunction

endpackage

// File: rtl/timer_channel.sv
// One HH:MM:SS countdown channel: setup/run/pause/expired FSM plus field counters.
// All state and the expiry pulse are registered; buttons arrive pre-prioritised and sel-gated.
module timer_channel
  import timer_pkg::*;
#(
  parameter int HOUR_MAX = 23
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick_i,
  input  logic        mode_i,
  input  logic        inc_i,
  input  logic        start_i,
  output logic [23:0] value_o,
  output ch_state_t   state_o,
  output logic        expire_pulse_o
);

  localparam logic [7:0] HOUR_TOP = 8'(HOUR_MAX);

  logic [7:0] sec_q, min_q, hour_q;
  ch_state_t  state_q;
  logic       pulse_q;
  logic       is_zero, is_one;

  assign is_zero = (hour_q == 8'd0) && (min_q == 8'd0) && (sec_q == 8'd0);
  assign is_one  = (hour_q == 8'd0) && (min_q == 8'd0) && (sec_q == 8'd1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sec_q   <= 8'd0;
      min_q   <= 8'd0;
      hour_q  <= 8'd0;
      state_q <= IDLE;
      pulse_q <= 1'b0;
    end else begin
      pulse_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (mode_i)                   state_q <= SET_SEC;
          else if (start_i && !is_zero) state_q <= RUN;
        end
        SET_SEC: begin
          if (mode_i)     state_q <= SET_MIN;
          else if (inc_i) sec_q   <= wrap_inc(sec_q, SEC_MAX);
        end
        SET_MIN: begin
          if (mode_i)     state_q <= SET_HOUR;
          else if (inc_i) min_q   <= wrap_inc(min_q, MIN_MAX);
        end
        SET_HOUR: begin
          if (mode_i)     state_q <= IDLE;
          else if (inc_i) hour_q  <= wrap_inc(hour_q, HOUR_TOP);
        end
        RUN: begin
          // A button in the tick cycle takes precedence; that tick is simply lost.
          if (mode_i)       state_q <= SET_SEC;
          else if (start_i) state_q <= PAUSE;
          else if (tick_i) begin
            if (is_one) begin
              sec_q   <= 8'd0;
              state_q <= EXPIRED;
              pulse_q <= 1'b1;
            end else if (sec_q != 8'd0) begin
              sec_q <= sec_q - 8'd1;
            end else begin
              sec_q <= SEC_MAX;
              if (min_q != 8'd0) begin
                min_q <= min_q - 8'd1;
              end else begin
                min_q  <= MIN_MAX;
                hour_q <= hour_q - 8'd1;
              end
            end
          end
        end
        PAUSE: begin
          if (mode_i)       state_q <= SET_SEC;
          else if (start_i) state_q <= RUN;
        end
        EXPIRED: begin
          if (mode_i)       state_q <= SET_SEC;
          else if (start_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    value_o                   = 24'd0;
    value_o[SEC_LSB  +: 8]    = sec_q;
    value_o[MIN_LSB  +: 8]    = min_q;
    value_o[HOUR_LSB +: 8]    = hour_q;
  end

  assign state_o        = state_q;
  assign expire_pulse_o = pulse_q;

endmodule

// File: rtl/countdown_timer_bank.sv
// Bank of N_CH countdown timers sharing a free-running 1 s prescaler and one button set.
// Buttons are prioritised mode > start > inc and steered to channel ch_sel; display is a comb mux.
module countdown_timer_bank
  import timer_pkg::*;
#(
  parameter  int CLK_HZ   = 50_000_000,
  parameter  int N_CH     = 4,
  parameter  int HOUR_MAX = 23,
  localparam int SEL_W    = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [SEL_W-1:0] ch_sel,
  input  logic             btn_mode,
  input  logic             btn_inc,
  input  logic             btn_start,
  output logic [23:0]      disp_data,
  output logic [1:0]       setup_field,
  output logic [N_CH-1:0]  running,
  output logic [N_CH-1:0]  expired,
  output logic [N_CH-1:0]  expire_pulse
);

  localparam int CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick;
  logic             sel_ok;
  logic             mode_g, start_g, inc_g;

  logic [23:0]      ch_value [N_CH];
  ch_state_t        ch_state [N_CH];

  assign tick  = (cnt_q == CNT_W'(CLK_HZ - 1));
  assign cnt_d = tick ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign sel_ok  = (int'(ch_sel) < N_CH);
  assign mode_g  = btn_mode & sel_ok;
  assign start_g = btn_start & ~btn_mode & sel_ok;
  assign inc_g   = btn_inc & ~btn_mode & ~btn_start & sel_ok;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    logic hit;
    assign hit = (ch_sel == SEL_W'(g));

    timer_channel #(.HOUR_MAX(HOUR_MAX)) u_ch (
      .clock          (clock),
      .reset          (reset),
      .tick_i         (tick),
      .mode_i         (mode_g & hit),
      .inc_i          (inc_g & hit),
      .start_i        (start_g & hit),
      .value_o        (ch_value[g]),
      .state_o        (ch_state[g]),
      .expire_pulse_o (expire_pulse[g])
    );

    assign running[g] = (ch_state[g] == RUN);
    assign expired[g] = (ch_state[g] == EXPIRED);
  end

  always_comb begin
    disp_data   = 24'd0;
    setup_field = 2'd0;
    for (int i = 0; i < N_CH; i++) begin
      if (sel_ok && (int'(ch_sel) == i)) begin
        disp_data   = ch_value[i];
        setup_field = field_code(ch_state[i]);
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer_bank.sv
// Directed bench for countdown_timer_bank with a queue of expected observations.
module tb_countdown_timer_bank;

  localparam int CLK_HZ = 10;
  localparam int N_CH   = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  ch_sel = 2'd0;
  logic        btn_mode = 1'b0, btn_inc = 1'b0, btn_start = 1'b0;
  logic [23:0] disp_data;
  logic [1:0]  setup_field;
  logic [3:0]  running, expired, expire_pulse;

  countdown_timer_bank #(.CLK_HZ(CLK_HZ), .N_CH(N_CH), .HOUR_MAX(23)) dut (
    .clock        (clock),
    .reset        (reset),
    .ch_sel       (ch_sel),
    .btn_mode     (btn_mode),
    .btn_inc      (btn_inc),
    .btn_start    (btn_start),
    .disp_data    (disp_data),
    .setup_field  (setup_field),
    .running      (running),
    .expired      (expired),
    .expire_pulse (expire_pulse)
  );

  always #5 clock = ~clock;

  // Reference prescaler phase: a tick edge follows any cycle where mcnt == CLK_HZ-1.
  int mcnt;
  always @(posedge clock or posedge reset) begin
    if (reset) mcnt <= 0;
    else       mcnt <= (mcnt == CLK_HZ - 1) ? 0 : mcnt + 1;
  end

  int pcnt0 = 0;
  int pany  = 0;
  always @(negedge clock) begin
    if (expire_pulse[0]) pcnt0 = pcnt0 + 1;
    if (|expire_pulse)   pany  = pany + 1;
  end

  typedef enum {K_DISP, K_FIELD, K_RUN, K_EXP, K_PULSE, K_PCNT0, K_PANY} kind_t;
  string       tagq[$];
  kind_t       kindq[$];
  logic [31:0] expq[$];

  int errors = 0;
  int checks = 0;

  task automatic expect_val(input string tag, input kind_t k, input logic [31:0] v);
    tagq.push_back(tag);
    kindq.push_back(k);
    expq.push_back(v);
  endtask

  function automatic logic [31:0] observe(input kind_t k);
    case (k)
      K_DISP:  return {8'd0, disp_data};
      K_FIELD: return {30'd0, setup_field};
      K_RUN:   return {28'd0, running};
      K_EXP:   return {28'd0, expired};
      K_PULSE: return {28'd0, expire_pulse};
      K_PCNT0: return 32'(pcnt0);
      default: return 32'(pany);
    endcase
  endfunction

  task automatic check_all();
    string       t;
    kind_t       k;
    logic [31:0] e, o;
    while (tagq.size() > 0) begin
      t = tagq.pop_front();
      k = kindq.pop_front();
      e = expq.pop_front();
      o = observe(k);
      checks = checks + 1;
      assert (o === e) else begin
        errors = errors + 1;
        $error("FAIL %s: observed=%0h expected=%0h", t, o, e);
      end
    end
  endtask

  task automatic press(input logic m, input logic i, input logic s);
    btn_mode  = m;
    btn_inc   = i;
    btn_start = s;
    @(posedge clock); #1;
    btn_mode  = 1'b0;
    btn_inc   = 1'b0;
    btn_start = 1'b0;
  endtask

  task automatic incs(input int n);
    repeat (n) press(1'b0, 1'b1, 1'b0);
  endtask

  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(negedge clock);
      while (mcnt != CLK_HZ - 1) @(negedge clock);
      @(posedge clock); #1;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // 1: reset values, then 100 idle cycles
    repeat (3) @(posedge clock);
    #1;
    expect_val("rst_disp", K_DISP, 32'h0);
    expect_val("rst_run",  K_RUN,  32'h0);
    expect_val("rst_exp",  K_EXP,  32'h0);
    check_all();
    @(negedge clock);
    reset = 1'b0;
    pany  = 0;
    repeat (100) @(posedge clock);
    #1;
    expect_val("idle_disp",  K_DISP,  32'h0);
    expect_val("idle_field", K_FIELD, 32'h0);
    expect_val("idle_run",   K_RUN,   32'h0);
    expect_val("idle_exp",   K_EXP,   32'h0);
    expect_val("idle_pany",  K_PANY,  32'h0);
    check_all();

    // 2: ch0 set 00:01:03, run to expiry, acknowledge
    ch_sel = 2'd0;
    press(1'b1, 1'b0, 1'b0);
    expect_val("c0_field_sec", K_FIELD, 32'd1);
    check_all();
    incs(3);
    press(1'b1, 1'b0, 1'b0);
    expect_val("c0_field_min", K_FIELD, 32'd2);
    check_all();
    incs(1);
    press(1'b1, 1'b0, 1'b0);
    expect_val("c0_field_hour", K_FIELD, 32'd3);
    check_all();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    expect_val("c0_start_disp", K_DISP, 32'h000103);
    expect_val("c0_start_run",  K_RUN,  32'h1);
    expect_val("c0_start_fld",  K_FIELD, 32'd0);
    check_all();
    pcnt0 = 0;
    wait_ticks(62);
    expect_val("c0_one_disp", K_DISP, 32'h000001);
    expect_val("c0_one_run",  K_RUN,  32'h1);
    expect_val("c0_one_exp",  K_EXP,  32'h0);
    check_all();
    wait_ticks(1);
    expect_val("c0_exp_disp",  K_DISP,  32'h0);
    expect_val("c0_exp_exp",   K_EXP,   32'h1);
    expect_val("c0_exp_run",   K_RUN,   32'h0);
    expect_val("c0_exp_pulse", K_PULSE, 32'h1);
    check_all();
    @(posedge clock); #1;
    expect_val("c0_pulse_gone", K_PULSE, 32'h0);
    expect_val("c0_pulse_cnt",  K_PCNT0, 32'd1);
    check_all();
    press(1'b0, 1'b0, 1'b1);
    expect_val("c0_ack_exp", K_EXP,  32'h0);
    expect_val("c0_ack_run", K_RUN,  32'h0);
    expect_val("c0_ack_disp", K_DISP, 32'h0);
    check_all();

    // 3: ch1 01:00:00, double borrow, pause, resume
    ch_sel = 2'd1;
    repeat (3) press(1'b1, 1'b0, 1'b0);
    incs(1);
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    expect_val("c1_start_disp", K_DISP, 32'h010000);
    expect_val("c1_start_run",  K_RUN,  32'h2);
    check_all();
    wait_ticks(1);
    expect_val("c1_borrow", K_DISP, 32'h003B3B);
    check_all();
    press(1'b0, 1'b0, 1'b1);
    expect_val("c1_pause_run", K_RUN, 32'h0);
    check_all();
    wait_ticks(30);
    expect_val("c1_paused_disp", K_DISP, 32'h003B3B);
    check_all();
    press(1'b0, 1'b0, 1'b1);
    expect_val("c1_resume_run", K_RUN, 32'h2);
    check_all();
    wait_ticks(1);
    expect_val("c1_resume_disp", K_DISP, 32'h003B3A);
    check_all();
    press(1'b0, 1'b0, 1'b1);

    // 4: setup wrap on ch0, start at zero stays idle
    ch_sel = 2'd0;
    press(1'b1, 1'b0, 1'b0);
    incs(59);
    expect_val("w_sec59", K_DISP, 32'h00003B);
    check_all();
    incs(1);
    expect_val("w_sec0", K_DISP, 32'h0);
    check_all();
    press(1'b1, 1'b0, 1'b0);
    press(1'b1, 1'b0, 1'b0);
    incs(23);
    expect_val("w_hour23", K_DISP, 32'h170000);
    check_all();
    incs(1);
    expect_val("w_hour0", K_DISP, 32'h0);
    check_all();
    press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    expect_val("w_zero_run",   K_RUN,   32'h0);
    expect_val("w_zero_field", K_FIELD, 32'd0);
    check_all();

    // 5: button in tick cycle on ch2 versus ch3 counting; mode+start priority
    ch_sel = 2'd2;
    press(1'b1, 1'b0, 1'b0);
    incs(10);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    ch_sel = 2'd3;
    press(1'b1, 1'b0, 1'b0);
    incs(10);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    wait_ticks(1);
    ch_sel = 2'd2;
    press(1'b0, 1'b0, 1'b1);
    ch_sel = 2'd3;
    press(1'b0, 1'b0, 1'b1);
    expect_val("t_both_run", K_RUN, 32'hC);
    check_all();
    wait_ticks(2);
    @(negedge clock);
    while (mcnt != CLK_HZ - 1) @(negedge clock);
    ch_sel = 2'd2;
    press(1'b0, 1'b0, 1'b1);
    expect_val("t_c2_hold", K_DISP, 32'h000008);
    expect_val("t_c2_run",  K_RUN,  32'h8);
    check_all();
    ch_sel = 2'd3;
    #1;
    expect_val("t_c3_dec", K_DISP, 32'h000007);
    check_all();
    ch_sel = 2'd0;
    press(1'b1, 1'b0, 1'b1);
    expect_val("p_mode_wins_fld", K_FIELD, 32'd1);
    expect_val("p_mode_wins_run", K_RUN,   32'h8);
    check_all();
    repeat (3) press(1'b1, 1'b0, 1'b0);

    // 6: reset just before the final tick of ch0
    incs(0);
    press(1'b1, 1'b0, 1'b0);
    incs(1);
    repeat (3) press(1'b1, 1'b0, 1'b0);
    press(1'b0, 1'b0, 1'b1);
    expect_val("r_pre_disp", K_DISP, 32'h000001);
    check_all();
    pcnt0 = 0;
    @(negedge clock);
    while (mcnt != CLK_HZ - 1) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    expect_val("r_disp", K_DISP,  32'h0);
    expect_val("r_run",  K_RUN,   32'h0);
    expect_val("r_exp",  K_EXP,   32'h0);
    expect_val("r_fld",  K_FIELD, 32'd0);
    check_all();
    reset = 1'b0;
    repeat (30) @(posedge clock);
    #1;
    expect_val("r_no_pulse", K_PCNT0, 32'd0);
    expect_val("r_after_exp", K_EXP,  32'h0);
    expect_val("r_after_disp", K_DISP, 32'h0);
    check_all();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
